// File: rtl/csr_regfile.sv
// CSR register file beside the writeback stage: combinational reads, masked writes, exception/ertn, timer, interrupts.
// Build option STABLE_COUNTER_EN adds a 64-bit free-running counter on stable_cnt (tied to zero otherwise).
module csr_regfile #(
    parameter logic [31:0] TID_INIT = 32'h0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        csr_re,
    input  logic [13:0] csr_num,
    output logic [31:0] csr_rvalue,
    input  logic        csr_we,
    input  logic [31:0] csr_wmask,
    input  logic [31:0] csr_wvalue,
    input  logic        wb_ex,
    input  logic [5:0]  wb_ecode,
    input  logic [8:0]  wb_esubcode,
    input  logic [31:0] wb_ex_pc,
    input  logic [31:0] wb_vaddr,
    input  logic        ertn_flush,
    input  logic [7:0]  hw_int_in,
    input  logic        ipi_int_in,
    output logic        has_int,
    output logic [63:0] stable_cnt
);
    localparam logic [13:0] A_CRMD   = 14'h00;
    localparam logic [13:0] A_PRMD   = 14'h01;
    localparam logic [13:0] A_ECFG   = 14'h04;
    localparam logic [13:0] A_ESTAT  = 14'h05;
    localparam logic [13:0] A_ERA    = 14'h06;
    localparam logic [13:0] A_BADV   = 14'h07;
    localparam logic [13:0] A_EENTRY = 14'h0C;
    localparam logic [13:0] A_SAVE0  = 14'h30;
    localparam logic [13:0] A_SAVE1  = 14'h31;
    localparam logic [13:0] A_SAVE2  = 14'h32;
    localparam logic [13:0] A_SAVE3  = 14'h33;
    localparam logic [13:0] A_TID    = 14'h40;
    localparam logic [13:0] A_TCFG   = 14'h41;
    localparam logic [13:0] A_TVAL   = 14'h42;
    localparam logic [13:0] A_TICLR  = 14'h44;
    localparam logic [5:0]  EC_ADEF  = 6'h08;
    localparam logic [5:0]  EC_ALE   = 6'h09;

    function automatic logic [31:0] mwrite(input logic [31:0] old, input logic [31:0] val,
                                           input logic [31:0] wmask, input logic [31:0] bits);
        logic [31:0] m;
        m = wmask & bits;
        return (old & ~m) | (val & m);
    endfunction

    logic [31:0] crmd_q, crmd_d, prmd_q, prmd_d, ecfg_q, ecfg_d, estat_q, estat_d;
    logic [31:0] era_q, era_d, badv_q, badv_d, eentry_q, eentry_d, tid_q, tid_d;
    logic [31:0] tcfg_q, tcfg_d, cnt_q, cnt_d;
    logic [31:0] save_q [4];
    logic [31:0] save_d [4];
    logic        tcfg_wr_s, ticlr_s, timer_fire_s;
    logic [31:0] rdata_s;

    assign timer_fire_s = tcfg_q[0] && (cnt_q == 32'h0);

    // Next-state for every register; wb_ex outranks ertn_flush, which outranks a software write.
    always_comb begin
        crmd_d = crmd_q;  prmd_d = prmd_q;  ecfg_d = ecfg_q;  estat_d = estat_q;
        era_d = era_q;    badv_d = badv_q;  eentry_d = eentry_q;  tid_d = tid_q;
        tcfg_d = tcfg_q;  save_d = save_q;
        tcfg_wr_s = 1'b0;
        ticlr_s   = 1'b0;
        if (wb_ex) begin
            prmd_d[2:0]    = crmd_q[2:0];
            crmd_d[2:0]    = 3'b000;
            era_d          = wb_ex_pc;
            estat_d[21:16] = wb_ecode;
            estat_d[30:22] = wb_esubcode;
            if (wb_ecode == EC_ADEF) begin
                badv_d = wb_ex_pc;
            end else if (wb_ecode == EC_ALE) begin
                badv_d = wb_vaddr;
            end else begin
                badv_d = badv_q;
            end
        end else if (ertn_flush) begin
            crmd_d[2:0] = prmd_q[2:0];
        end else if (csr_we) begin
            case (csr_num)
                A_CRMD:   crmd_d   = mwrite(crmd_q, csr_wvalue, csr_wmask, 32'h0000_01FF);
                A_PRMD:   prmd_d   = mwrite(prmd_q, csr_wvalue, csr_wmask, 32'h0000_0007);
                A_ECFG:   ecfg_d   = mwrite(ecfg_q, csr_wvalue, csr_wmask, 32'h0000_1BFF);
                A_ESTAT:  estat_d  = mwrite(estat_q, csr_wvalue, csr_wmask, 32'h0000_0003);
                A_ERA:    era_d    = mwrite(era_q, csr_wvalue, csr_wmask, 32'hFFFF_FFFF);
                A_BADV:   badv_d   = mwrite(badv_q, csr_wvalue, csr_wmask, 32'hFFFF_FFFF);
                A_EENTRY: eentry_d = mwrite(eentry_q, csr_wvalue, csr_wmask, 32'hFFFF_FFC0);
                A_SAVE0, A_SAVE1, A_SAVE2, A_SAVE3:
                    save_d[csr_num[1:0]] = mwrite(save_q[csr_num[1:0]], csr_wvalue, csr_wmask, 32'hFFFF_FFFF);
                A_TID:    tid_d    = mwrite(tid_q, csr_wvalue, csr_wmask, 32'hFFFF_FFFF);
                A_TCFG: begin
                    tcfg_d    = mwrite(tcfg_q, csr_wvalue, csr_wmask, 32'hFFFF_FFFF);
                    tcfg_wr_s = 1'b1;
                end
                A_TICLR:  ticlr_s  = csr_wvalue[0] & csr_wmask[0];
                default:  crmd_d   = crmd_q;
            endcase
        end else begin
            crmd_d = crmd_q;
        end

        estat_d[9:2] = hw_int_in;
        estat_d[12]  = ipi_int_in;
        // A timer expiry in the same cycle as a TICLR write keeps the interrupt pending.
        if (timer_fire_s) begin
            estat_d[11] = 1'b1;
        end else if (ticlr_s) begin
            estat_d[11] = 1'b0;
        end else begin
            estat_d[11] = estat_q[11];
        end

        if (tcfg_wr_s) begin
            cnt_d = {tcfg_d[31:2], 2'b00};
        end else if (timer_fire_s) begin
            cnt_d = tcfg_q[1] ? {tcfg_q[31:2], 2'b00} : 32'hFFFF_FFFF;
        end else if (tcfg_q[0] && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q - 32'h1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            crmd_q <= 32'h0000_0008;  prmd_q <= 32'h0;  ecfg_q <= 32'h0;  estat_q <= 32'h0;
            era_q <= 32'h0;  badv_q <= 32'h0;  eentry_q <= 32'h0;  tid_q <= TID_INIT;
            tcfg_q <= 32'h0;  cnt_q <= 32'hFFFF_FFFF;
            for (int i = 0; i < 4; i++) save_q[i] <= 32'h0;
        end else begin
            crmd_q <= crmd_d;  prmd_q <= prmd_d;  ecfg_q <= ecfg_d;  estat_q <= estat_d;
            era_q <= era_d;  badv_q <= badv_d;  eentry_q <= eentry_d;  tid_q <= tid_d;
            tcfg_q <= tcfg_d;  cnt_q <= cnt_d;
            save_q <= save_d;
        end
    end

    // Zero-latency read mux; unmapped addresses and TICLR read as zero.
    always_comb begin
        rdata_s = 32'h0;
        if (csr_re) begin
            case (csr_num)
                A_CRMD:   rdata_s = crmd_q;
                A_PRMD:   rdata_s = prmd_q;
                A_ECFG:   rdata_s = ecfg_q;
                A_ESTAT:  rdata_s = estat_q;
                A_ERA:    rdata_s = era_q;
                A_BADV:   rdata_s = badv_q;
                A_EENTRY: rdata_s = eentry_q;
                A_SAVE0, A_SAVE1, A_SAVE2, A_SAVE3: rdata_s = save_q[csr_num[1:0]];
                A_TID:    rdata_s = tid_q;
                A_TCFG:   rdata_s = tcfg_q;
                A_TVAL:   rdata_s = cnt_q;
                default:  rdata_s = 32'h0;
            endcase
        end else begin
            rdata_s = 32'h0;
        end
    end

    assign csr_rvalue = rdata_s;
    assign has_int    = crmd_q[2] & (|(estat_q[12:0] & ecfg_q[12:0]));

`ifdef STABLE_COUNTER_EN
    logic [63:0] stable_q;

    // Free-running counter, wraps naturally at 2^64.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stable_q <= 64'h0;
        end else begin
            stable_q <= stable_q + 64'h1;
        end
    end

    assign stable_cnt = stable_q;
`else
    assign stable_cnt = 64'h0;
`endif

endmodule

// File: tb/tb_csr_regfile.sv
// Scoreboard bench for csr_regfile: reads push expected values, a negedge monitor pops and compares.
module tb_csr_regfile;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        csr_re = 1'b0, csr_we = 1'b0, wb_ex = 1'b0, ertn_flush = 1'b0, ipi_int_in = 1'b0;
    logic [13:0] csr_num = 14'h0;
    logic [31:0] csr_rvalue, csr_wmask = 32'h0, csr_wvalue = 32'h0, wb_ex_pc = 32'h0, wb_vaddr = 32'h0;
    logic [5:0]  wb_ecode = 6'h0;
    logic [8:0]  wb_esubcode = 9'h0;
    logic [7:0]  hw_int_in = 8'h0;
    logic        has_int;
    logic [63:0] stable_cnt;

    typedef struct packed {
        logic [31:0] rd;
        logic        ci;
        logic        ei;
        logic        cs;
        logic [63:0] es;
    } exp_t;

    exp_t  exp_q [$];
    string tag_q [$];
    int    checks = 0;
    int    errors = 0;

    csr_regfile dut (
        .clk(clk), .resetn(resetn), .csr_re(csr_re), .csr_num(csr_num), .csr_rvalue(csr_rvalue),
        .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue), .wb_ex(wb_ex),
        .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_ex_pc(wb_ex_pc), .wb_vaddr(wb_vaddr),
        .ertn_flush(ertn_flush), .hw_int_in(hw_int_in), .ipi_int_in(ipi_int_in),
        .has_int(has_int), .stable_cnt(stable_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (csr_re) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_read: rvalue=%h with empty scoreboard", csr_rvalue);
            end else begin
                exp_t  e;
                string t;
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                checks++;
                if (csr_rvalue !== e.rd) begin
                    errors++;
                    $display("FAIL %s: rvalue got %h want %h", t, csr_rvalue, e.rd);
                end
                if (e.ci) begin
                    checks++;
                    if (has_int !== e.ei) begin
                        errors++;
                        $display("FAIL %s_has_int: got %b want %b", t, has_int, e.ei);
                    end
                end
                if (e.cs) begin
                    checks++;
                    if (stable_cnt !== e.es) begin
                        errors++;
                        $display("FAIL %s_stable_cnt: got %0d want %0d", t, stable_cnt, e.es);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic push_rd(input logic [13:0] num, input logic [31:0] e, input logic ci, input logic ei,
                           input logic cs, input logic [63:0] es, input string tag);
        exp_t x;
        x.rd = e; x.ci = ci; x.ei = ei; x.cs = cs; x.es = es;
        exp_q.push_back(x);
        tag_q.push_back(tag);
        csr_re = 1'b1; csr_num = num;
        tick();
        csr_re = 1'b0;
    endtask

    task automatic rd(input logic [13:0] num, input logic [31:0] e, input string tag);
        push_rd(num, e, 1'b0, 1'b0, 1'b0, 64'h0, tag);
    endtask

    task automatic rdi(input logic [13:0] num, input logic [31:0] e, input logic ei, input string tag);
        push_rd(num, e, 1'b1, ei, 1'b0, 64'h0, tag);
    endtask

    task automatic wr(input logic [13:0] num, input logic [31:0] m, input logic [31:0] v);
        csr_we = 1'b1; csr_num = num; csr_wmask = m; csr_wvalue = v;
        tick();
        csr_we = 1'b0;
    endtask

    task automatic ex(input logic [5:0] ec, input logic [8:0] sub, input logic [31:0] pc, input logic [31:0] va);
        wb_ex = 1'b1; wb_ecode = ec; wb_esubcode = sub; wb_ex_pc = pc; wb_vaddr = va;
        tick();
        wb_ex = 1'b0;
    endtask

    task automatic do_reset();
        tick();
        resetn = 1'b0;
        csr_re = 1'b0; csr_we = 1'b0; wb_ex = 1'b0; ertn_flush = 1'b0;
        hw_int_in = 8'h0; ipi_int_in = 1'b0;
        tick();
        resetn = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached with %0d reads pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        // Reset state and basic masked writes.
        push_rd(14'h00, 32'h0000_0008, 1'b1, 1'b0, 1'b1, 64'h0, "reset_crmd");
        rd(14'h40, 32'h0, "reset_tid");
        rd(14'h42, 32'hFFFF_FFFF, "reset_tval");
        wr(14'h00, 32'h7, 32'h5);
        rd(14'h00, 32'h0000_000D, "crmd_masked");
        wr(14'h0C, 32'hFFFF_FFFF, 32'h1C00_0FFF);
        rd(14'h0C, 32'h1C00_0FC0, "eentry_low_bits");
        wr(14'h04, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rd(14'h04, 32'h0000_1BFF, "ecfg_writable");
        wr(14'h40, 32'hFFFF_0000, 32'h1234_5678);
        rd(14'h40, 32'h1234_0000, "tid_masked");
        wr(14'h10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rd(14'h10, 32'h0, "unmapped");
        rd(14'h44, 32'h0, "ticlr_reads_zero");
        wr(14'h32, 32'hFFFF_FFFF, 32'hA5A5_5A5A);
        rd(14'h32, 32'hA5A5_5A5A, "save2");

        // Exception entry, ertn, BADV selection by ecode.
        do_reset();
        wr(14'h00, 32'hFFFF_FFFF, 32'h7);
        ex(6'h09, 9'h0, 32'h1C00_0100, 32'h0000_1003);
        rd(14'h01, 32'h7, "ex_prmd");
        rd(14'h00, 32'h0, "ex_crmd");
        rd(14'h06, 32'h1C00_0100, "ex_era");
        rd(14'h07, 32'h0000_1003, "ale_badv");
        rd(14'h05, 32'h0009_0000, "ex_estat");
        ertn_flush = 1'b1; tick(); ertn_flush = 1'b0;
        rd(14'h00, 32'h7, "ertn_crmd");
        ex(6'h08, 9'h1, 32'h1C00_0200, 32'h0000_ABCD);
        rd(14'h07, 32'h1C00_0200, "adef_badv");
        rd(14'h05, 32'h0048_0000, "adef_estat");
        ex(6'h0B, 9'h0, 32'h1C00_0300, 32'h0000_5555);
        rd(14'h07, 32'h1C00_0200, "other_badv_kept");
        rd(14'h01, 32'h0, "ex_prmd_from_zero");

        // One-shot then periodic timer.
        do_reset();
        wr(14'h41, 32'hFFFF_FFFF, 32'h0000_0011);
        for (int i = 16; i >= 0; i--) rd(14'h42, 32'(i), "oneshot_tval");
        rd(14'h05, 32'h0000_0800, "oneshot_is11");
        rd(14'h42, 32'hFFFF_FFFF, "oneshot_wrap");
        rd(14'h42, 32'hFFFF_FFFF, "oneshot_hold");
        do_reset();
        wr(14'h41, 32'hFFFF_FFFF, 32'h0000_0013);
        for (int i = 16; i >= 0; i--) rd(14'h42, 32'(i), "periodic_tval");
        rd(14'h42, 32'd16, "periodic_reload");
        rd(14'h42, 32'd15, "periodic_after_reload");

        // Timer interrupt, TICLR, and set-beats-clear.
        do_reset();
        wr(14'h04, 32'hFFFF_FFFF, 32'h0000_0800);
        wr(14'h00, 32'h4, 32'h4);
        wr(14'h41, 32'hFFFF_FFFF, 32'h1);
        rdi(14'h42, 32'h0, 1'b0, "tmr_before_fire");
        rdi(14'h05, 32'h0000_0800, 1'b1, "tmr_fired");
        wr(14'h44, 32'h1, 32'h1);
        rdi(14'h05, 32'h0, 1'b0, "ticlr_clear");
        wr(14'h41, 32'hFFFF_FFFF, 32'h1);
        wr(14'h44, 32'h1, 32'h1);
        rdi(14'h05, 32'h0000_0800, 1'b1, "set_beats_clear");

        // Same-cycle priority and EENTRY fetch during exception.
        do_reset();
        wr(14'h0C, 32'hFFFF_FFFF, 32'h1C00_8000);
        wb_ex = 1'b1; wb_ecode = 6'h0; wb_esubcode = 9'h0; wb_ex_pc = 32'h1C00_0400;
        wr(14'h06, 32'hFFFF_FFFF, 32'hDEAD_BEEF);
        wb_ex = 1'b0;
        rd(14'h06, 32'h1C00_0400, "ex_beats_we");
        wb_ex = 1'b1; wb_ex_pc = 32'h1C00_0500;
        rd(14'h0C, 32'h1C00_8000, "ex_eentry_fetch");
        wb_ex = 1'b0;
        rd(14'h06, 32'h1C00_0500, "ex_era2");
        ertn_flush = 1'b1;
        wr(14'h00, 32'hFFFF_FFFF, 32'h0000_01FF);
        ertn_flush = 1'b0;
        rd(14'h00, 32'h0000_0008, "ertn_beats_we");

        // Hardware/IPI interrupts and asynchronous reset mid-countdown.
        do_reset();
        wr(14'h04, 32'hFFFF_FFFF, 32'h0000_0004);
        wr(14'h00, 32'h4, 32'h4);
        hw_int_in = 8'h01;
        rdi(14'h05, 32'h0, 1'b0, "hw_not_yet");
        rdi(14'h05, 32'h0000_0004, 1'b1, "hw_int");
        ipi_int_in = 1'b1;
        rd(14'h05, 32'h0000_0004, "ipi_not_yet");
        rd(14'h05, 32'h0000_1004, "ipi_sampled");
        wr(14'h41, 32'hFFFF_FFFF, 32'h0000_0011);
        tick(); tick();
        resetn = 1'b0;
        rdi(14'h00, 32'h0000_0008, 1'b0, "async_rst_crmd");
        rd(14'h42, 32'hFFFF_FFFF, "async_rst_tval");
        rd(14'h05, 32'h0, "async_rst_estat");
        hw_int_in = 8'h0; ipi_int_in = 1'b0;
        resetn = 1'b1;

        // Stable counter after 100 cycles (zero when the counter is not built).
        do_reset();
        repeat (100) tick();
`ifdef STABLE_COUNTER_EN
        push_rd(14'h00, 32'h0000_0008, 1'b0, 1'b0, 1'b1, 64'd100, "stable_100");
`else
        push_rd(14'h00, 32'h0000_0008, 1'b0, 1'b0, 1'b1, 64'd0, "stable_off");
`endif

        tick(); tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d reads left unchecked, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
